instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Program counter, instruction register and 8-level hardware return stack for the PIC16F core. Drives the program-memory address, latches the fetched word into the instruction register that feeds the instruction decoder, and applies the decoder's fetch controls each cycle: increment, jump, call, return, flush/skip and computed PCL writes. All state is registered. Outputs are stable for the whole 4-cycle Q sequence except at the cycle where the decoder requests an update.

## Interface
Parameters:
- STACK_DEPTH, 8: return-stack entries; power of two.
- PC_W, 13: program counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- instr_rd_en  in  1  load prog_data into the instruction register.
- instr_flush  in  1  load NOP (14'h0000) into the instruction register; overrides instr_rd_en.
- pc_incr_en  in  1  PC <= PC + 1.
- pc_j_en  in  1  PC <= {pclath[4:3], instr_current[10:0]}.
- call_en  in  1  qualifies pc_j_en as CALL: push PC before the jump.
- ret_en  in  1  PC <= top of stack, then pop.
- pcl_wr_en  in  1  computed jump: PC <= {pclath[4:0], pcl_wdata}.
- pcl_wdata  in  8  new PCL value.
- pclath  in  5  PCLATH register contents.
- prog_data  in  14  program-memory read data; combinational from prog_addr.
- prog_addr  out  PC_W  equals pc.
- pc  out  PC_W  current program counter.
- instr_current  out  14  instruction register.
- stack_ovf  out  1  sticky: a push occurred with the stack full.
- stack_unf  out  1  sticky: a pop occurred with the stack empty.

## Operation
- PC always addresses the next word to be loaded. While instr_current holds the instruction at address A, pc = A+1.
- Instruction register update, per edge: instr_flush loads 14'h0000. Otherwise instr_rd_en loads prog_data. Otherwise it holds.
- PC update priority, highest first:
  - ret_en: PC <= stack[top]; pointer decrements.
  - pc_j_en & call_en: stack[top+1] <= PC; pointer increments; PC <= jump target.
  - pc_j_en: PC <= jump target.
  - pcl_wr_en: PC <= {pclath, pcl_wdata}.
  - pc_incr_en: PC <= PC + 1.
  - none: PC holds.
- Only the highest-priority PC action takes effect. For example, ret_en with pc_j_en & call_en performs the return only, with no push.
- call_en without pc_j_en is ignored.
- PC increment wraps at 2^PC_W: 13'h1FFF + 1 = 13'h0000.
- The stack is circular. The pointer is log2(STACK_DEPTH) bits and wraps. Occupancy is tracked separately, range 0..STACK_DEPTH.
- Push at occupancy STACK_DEPTH: the oldest entry is overwritten, stack_ovf is set, and occupancy stays STACK_DEPTH.
- Pop at occupancy 0: PC loads whatever entry the pointer addresses, stack_unf is set, the pointer still decrements, and occupancy stays 0.
- stack_ovf and stack_unf clear only on reset.
- Skip (decfsz/incfsz): the decoder asserts instr_flush with pc_incr_en. The word at PC is never loaded and PC advances past it.

## Timing
- Reset (rst = 0), immediately and asynchronously: pc = 0, instr_current = 14'h0000, stack pointer = 0, occupancy = 0, stack_ovf = 0, stack_unf = 0. Stack contents are not reset.
- Deassertion takes effect at the first rising edge with rst = 1.
- Reset asserted mid-sequence aborts any push or pop. After release the core refetches from address 0.
- Latency: control inputs sampled at edge N are visible on pc and instr_current after edge N, i.e. in cycle N+1.
- prog_addr follows pc combinationally. prog_data must be valid within the same cycle.
- Pipeline: a branch loads NOP at its Q3 edge. The target instruction is loaded at the Q3 edge of the following NOP sequence, giving 8 cycles in total.

## Test plan
- Reset then NOP stream: memory is all 14'h0000. Expect pc to increment by 1 every 4th cycle and instr_current to stay 0. Asserting rst at pc = 5 gives pc = 0 immediately.
- Sequential fetch: mem[0] = movlw 0x12, mem[1] = addwf. After the first Q3 edge, instr_current = mem[0] and pc = 1. After the next Q3 edge, instr_current = mem[1] and pc = 2.
- GOTO 0x345 with pclath = 5'b11000: at the Q3 edge pc = 13'h1B45 and instr_current = 0. Four cycles later instr_current = mem[13'h1B45].
- CALL at address 0x010 to 0x100, then RETURN: the push stores 0x011 and pc becomes 0x100. On ret_en, pc = 0x011 and occupancy returns to 0.
- Nine nested calls from addresses 0..8: stack_ovf = 1 after the ninth call. Nine returns yield 0x009 down to 0x002, then 0x009 again (the overwritten slot), and stack_unf = 1 on the ninth return.
- Skip and PCL write:
  - instr_flush with pc_incr_en at pc = 0x020 gives instr_current = 0 and pc = 0x021; mem[0x020] is never loaded.
  - pcl_wr_en with pc_incr_en, pcl_wdata = 0x80 and pclath = 0x02 gives pc = 0x0280.
  - 13'h1FFF + incr gives pc = 0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: decoder fetch controls, program-memory port and fetch state outputs.
interface instruction_fetch_if #(
   parameter int unsigned PC_W = 13
);
   logic            instr_rd_en;
   logic            instr_flush;
   logic            pc_incr_en;
   logic            pc_j_en;
   logic            call_en;
   logic            ret_en;
   logic            pcl_wr_en;
   logic [7:0]      pcl_wdata;
   logic [4:0]      pclath;
   logic [13:0]     prog_data;
   logic [PC_W-1:0] prog_addr;
   logic [PC_W-1:0] pc;
   logic [13:0]     instr_current;
   logic            stack_ovf;
   logic            stack_unf;

   // Decoder / program-memory side
   modport master (
      output instr_rd_en, instr_flush, pc_incr_en, pc_j_en, call_en, ret_en,
             pcl_wr_en, pcl_wdata, pclath, prog_data,
      input  prog_addr, pc, instr_current, stack_ovf, stack_unf
   );

   // Fetch-unit side
   modport slave (
      input  instr_rd_en, instr_flush, pc_incr_en, pc_j_en, call_en, ret_en,
             pcl_wr_en, pcl_wdata, pclath, prog_data,
      output prog_addr, pc, instr_current, stack_ovf, stack_unf
   );
endinterface

// File: rtl/instruction_fetch.sv
// PIC16F program counter, instruction register and circular hardware return stack.
module instruction_fetch #(
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned PC_W        = 13
) (
   input  logic               clk,
   input  logic               rst,
   instruction_fetch_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
   localparam int unsigned OCC_W = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IR_W  = 14;

   logic [PC_W-1:0]  pc_q,  pc_d;
   logic [IR_W-1:0]  ir_q,  ir_d;
   logic [PTR_W-1:0] sp_q,  sp_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             push_c;
   logic [PC_W-1:0]  jmp_target_c;
   logic [PC_W-1:0]  stack_q [STACK_DEPTH];

   // Jump target: page bits from PCLATH, low 11 bits from the opcode
   assign jmp_target_c = PC_W'({bus.pclath[4:3], ir_q[10:0]});

   // Instruction register next value: flush beats load
   always_comb begin
      ir_d = ir_q;
      if (bus.instr_flush)
         ir_d = '0;
      else if (bus.instr_rd_en)
         ir_d = bus.prog_data;
   end

   // PC and stack bookkeeping: single highest-priority action per edge
   always_comb begin
      pc_d   = pc_q;
      sp_d   = sp_q;
      occ_d  = occ_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      push_c = 1'b0;
      if (bus.ret_en) begin
         pc_d = stack_q[sp_q];
         sp_d = PTR_W'(sp_q - PTR_W'(1));
         if (occ_q == '0)
            unf_d = 1'b1;
         else
            occ_d = OCC_W'(occ_q - OCC_W'(1));
      end else if (bus.pc_j_en && bus.call_en) begin
         push_c = 1'b1;
         pc_d   = jmp_target_c;
         sp_d   = PTR_W'(sp_q + PTR_W'(1));
         if (occ_q == OCC_W'(STACK_DEPTH))
            ovf_d = 1'b1;
         else
            occ_d = OCC_W'(occ_q + OCC_W'(1));
      end else if (bus.pc_j_en) begin
         pc_d = jmp_target_c;
      end else if (bus.pcl_wr_en) begin
         pc_d = PC_W'({bus.pclath, bus.pcl_wdata});
      end else if (bus.pc_incr_en) begin
         pc_d = PC_W'(pc_q + PC_W'(1));
      end
   end

   // Fetch state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= '0;
         ir_q  <= '0;
         sp_q  <= '0;
         occ_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         sp_q  <= sp_d;
         occ_q <= occ_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Stack storage is not reset; a push is dropped while reset is held
   always_ff @(posedge clk) begin
      if (rst && push_c)
         stack_q[sp_d] <= pc_q;
   end

   // Outputs
   assign bus.pc            = pc_q;
   assign bus.prog_addr     = pc_q;
   assign bus.instr_current = ir_q;
   assign bus.stack_ovf     = ovf_q;
   assign bus.stack_unf     = unf_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: per-cycle expected state queued at drive time.
module tb_instruction_fetch;
   logic clk = 1'b0;
   logic rst = 1'b0;

   instruction_fetch_if #(.PC_W(13)) ifc ();

   instruction_fetch #(.STACK_DEPTH(8), .PC_W(13)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   logic [13:0] mem [0:8191];
   assign ifc.prog_data = mem[ifc.prog_addr];

   typedef struct packed {
      logic [12:0] pc;
      logic [13:0] ir;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // Reference state
   logic [12:0] m_pc;
   logic [13:0] m_ir;
   logic [12:0] m_stack [8];
   int          m_sp, m_occ;
   logic        m_ovf, m_unf;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = '0; m_ir = '0; m_sp = 0; m_occ = 0; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   // Drive one cycle of controls, queue the expected post-edge state, then compare.
   task automatic step(input bit rd, input bit flush, input bit incr, input bit j,
                       input bit call, input bit ret, input bit pclw, input logic [7:0] wd);
      logic [12:0] nxt_pc;
      logic [13:0] nxt_ir;
      logic [12:0] target;
      exp_t e, got;
      ifc.instr_rd_en = rd;  ifc.instr_flush = flush; ifc.pc_incr_en = incr;
      ifc.pc_j_en = j;       ifc.call_en = call;      ifc.ret_en = ret;
      ifc.pcl_wr_en = pclw;  ifc.pcl_wdata = wd;
      nxt_ir = flush ? 14'h0000 : (rd ? mem[m_pc] : m_ir);
      target = {ifc.pclath[4:3], m_ir[10:0]};
      nxt_pc = m_pc;
      if (ret) begin
         nxt_pc = m_stack[m_sp];
         m_sp = (m_sp + 7) % 8;
         if (m_occ == 0) m_unf = 1'b1; else m_occ--;
      end else if (j && call) begin
         m_sp = (m_sp + 1) % 8;
         m_stack[m_sp] = m_pc;
         nxt_pc = target;
         if (m_occ == 8) m_ovf = 1'b1; else m_occ++;
      end else if (j) nxt_pc = target;
      else if (pclw) nxt_pc = {ifc.pclath, wd};
      else if (incr) nxt_pc = m_pc + 13'd1;
      m_pc = nxt_pc;
      m_ir = nxt_ir;
      sb_q.push_back('{pc: m_pc, ir: m_ir, ovf: m_ovf, unf: m_unf});
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      got = '{pc: ifc.pc, ir: ifc.instr_current, ovf: ifc.stack_ovf, unf: ifc.stack_unf};
      check_val("pc", 32'(got.pc), 32'(e.pc));
      check_val("instr", 32'(got.ir), 32'(e.ir));
      check_val("ovf", 32'(got.ovf), 32'(e.ovf));
      check_val("unf", 32'(got.unf), 32'(e.unf));
      check_val("prog_addr", 32'(ifc.prog_addr), 32'(e.pc));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   // One 4-cycle Q sequence ending in a fetch at Q3
   task automatic fetch_seq();
      idle(3);
      step(1, 0, 1, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic set_pc(input logic [4:0] lath, input logic [7:0] lo);
      ifc.pclath = lath;
      step(0, 0, 0, 0, 0, 0, 1, lo);
   endtask

   task automatic reset_check(input string tag);
      rst = 1'b0;
      #1;
      check_val({tag, "_pc"}, 32'(ifc.pc), 32'h0);
      check_val({tag, "_ir"}, 32'(ifc.instr_current), 32'h0);
      check_val({tag, "_ovf"}, 32'(ifc.stack_ovf), 32'h0);
      check_val({tag, "_unf"}, 32'(ifc.stack_unf), 32'h0);
      @(posedge clk);
      #1;
      ifc.instr_rd_en = 0; ifc.instr_flush = 0; ifc.pc_incr_en = 0; ifc.pc_j_en = 0;
      ifc.call_en = 0; ifc.ret_en = 0; ifc.pcl_wr_en = 0;
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0] ret_exp [9];
      for (int i = 0; i < 8192; i++) mem[i] = 14'h0000;
      for (int i = 0; i < 8; i++) m_stack[i] = '0;
      ifc.instr_rd_en = 0; ifc.instr_flush = 0; ifc.pc_incr_en = 0; ifc.pc_j_en = 0;
      ifc.call_en = 0; ifc.ret_en = 0; ifc.pcl_wr_en = 0; ifc.pcl_wdata = '0;
      ifc.pclath = '0;
      model_reset();
      @(posedge clk);
      #1;
      reset_check("rst0");

      // NOP stream, then asynchronous reset at pc = 5
      for (int i = 0; i < 5; i++) fetch_seq();
      check_val("nop_pc5", 32'(ifc.pc), 32'h5);
      #2;
      reset_check("rst_mid");

      // Sequential fetch from address 0
      mem[0] = 14'h3012;
      mem[1] = 14'h0720;
      fetch_seq();
      check_val("seq0_ir", 32'(ifc.instr_current), 32'h3012);
      check_val("seq0_pc", 32'(ifc.pc), 32'h1);
      fetch_seq();
      check_val("seq1_ir", 32'(ifc.instr_current), 32'h0720);
      check_val("seq1_pc", 32'(ifc.pc), 32'h2);

      // GOTO 0x345 with PCLATH = 11000b
      mem[2] = 14'h2B45;
      mem[13'h1B45] = 14'h3055;
      fetch_seq();
      ifc.pclath = 5'b11000;
      idle(3);
      step(0, 1, 0, 1, 0, 0, 0, 8'h00);
      check_val("goto_pc", 32'(ifc.pc), 32'h1B45);
      check_val("goto_ir", 32'(ifc.instr_current), 32'h0);
      idle(3);
      step(1, 0, 1, 0, 0, 0, 0, 8'h00);
      check_val("goto_tgt_ir", 32'(ifc.instr_current), 32'h3055);

      // CALL at 0x010 to 0x100, then RETURN
      mem[13'h010] = 14'h2100;
      mem[13'h100] = 14'h0008;
      set_pc(5'h00, 8'h10);
      fetch_seq();
      idle(3);
      step(0, 1, 0, 1, 1, 0, 0, 8'h00);
      check_val("call_pc", 32'(ifc.pc), 32'h100);
      fetch_seq();
      idle(3);
      step(0, 1, 0, 0, 0, 1, 0, 8'h00);
      check_val("ret_pc", 32'(ifc.pc), 32'h011);
      check_val("ret_unf", 32'(ifc.stack_unf), 32'h0);

      // call_en alone is ignored; ret_en beats pc_j_en & call_en
      step(0, 0, 1, 0, 1, 0, 0, 8'h00);
      check_val("call_only_pc", 32'(ifc.pc), 32'h012);

      // Nine nested calls, pushing 1..9
      for (int i = 0; i < 9; i++) begin
         set_pc(5'h00, 8'(i + 1));
         step(0, 0, 0, 1, 1, 0, 0, 8'h00);
         check_val("nest_ovf", 32'(ifc.stack_ovf), (i == 8) ? 32'h1 : 32'h0);
      end
      ret_exp = '{13'h9, 13'h8, 13'h7, 13'h6, 13'h5, 13'h4, 13'h3, 13'h2, 13'h9};
      for (int i = 0; i < 9; i++) begin
         if (i == 0) step(0, 0, 0, 1, 1, 1, 0, 8'h00);
         else        step(0, 0, 0, 0, 0, 1, 0, 8'h00);
         check_val("nest_ret_pc", 32'(ifc.pc), 32'(ret_exp[i]));
         check_val("nest_unf", 32'(ifc.stack_unf), (i == 8) ? 32'h1 : 32'h0);
      end

      // Skip: flush with increment never loads the skipped word
      mem[13'h020] = 14'h3FFF;
      set_pc(5'h00, 8'h20);
      step(0, 1, 1, 0, 0, 0, 0, 8'h00);
      check_val("skip_ir", 32'(ifc.instr_current), 32'h0);
      check_val("skip_pc", 32'(ifc.pc), 32'h021);

      // PCL write beats increment
      ifc.pclath = 5'h02;
      step(0, 0, 1, 0, 0, 0, 1, 8'h80);
      check_val("pcl_pc", 32'(ifc.pc), 32'h0280);

      // Increment wraps at the top of the address space
      set_pc(5'h1F, 8'hFF);
      check_val("top_pc", 32'(ifc.pc), 32'h1FFF);
      step(0, 0, 1, 0, 0, 0, 0, 8'h00);
      check_val("wrap_pc", 32'(ifc.pc), 32'h0);

      // Reset during a CALL clears the sticky flags and aborts the push
      ifc.pc_j_en = 1'b1;
      ifc.call_en = 1'b1;
      reset_check("rst_call");
      step(0, 0, 1, 0, 0, 0, 0, 8'h00);
      check_val("post_rst_pc", 32'(ifc.pc), 32'h1);

      if (sb_q.size() != 0) check_val("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
